// File: rtl/ff_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ff_ctrl_pkg : shared encodings for the flip-flop mode sequencer             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package ff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam logic [1:0] MODE_00 = 2'b00;
  localparam logic [1:0] MODE_01 = 2'b01;
  localparam logic [1:0] MODE_10 = 2'b10;
  localparam logic [1:0] MODE_11 = 2'b11;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin arbiter; update favours the loser next time   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module rr_arb2
  import ff_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_idx_o,
  output logic       any_o
);

  logic prio_q;

  assign any_o     = |req_i;
  assign gnt_idx_o = (&req_i) ? prio_q : req_i[1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= REQ_A;
    end else if (update_i) begin
      prio_q <= ~gnt_idx_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ff_mode_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ff_mode_sequencer : shares one mode-selectable flip-flop datapath between   |
// | two requesters, pulsing the datapath reset on mode changes.  Rev 1.0        |
// +-----------------------------------------------------------------------------+
module ff_mode_sequencer
  import ff_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int MAX_BURST  = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_a_i,
  input  logic [1:0] mode_a_i,
  input  logic [2:0] xyz_a_i,
  output logic       gnt_a_o,
  output logic       t_a_o,
  output logic       t_valid_a_o,
  input  logic       req_b_i,
  input  logic [1:0] mode_b_i,
  input  logic [2:0] xyz_b_i,
  output logic       gnt_b_o,
  output logic       t_b_o,
  output logic       t_valid_b_o,
  output logic       dp_x_o,
  output logic       dp_y_o,
  output logic       dp_z_o,
  output logic       dp_s0_o,
  output logic       dp_s1_o,
  output logic       dp_reset_o,
  input  logic       dp_t_i
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_e           state_q, state_d;
  logic             win_id_q, win_id_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [1:0]       dp_s_q, dp_s_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] burst_q, burst_d, burst_inc;
  logic [2:0]       dp_xyz_q, dp_xyz_d;
  logic             dp_reset_q, dp_reset_d;
  tag_t             tag1_q, tag1_d, tag2_q;

  logic [1:0] arb_req;
  logic       arb_update, arb_gnt_idx, arb_any;
  logic       win_req, run_act;
  logic [2:0] win_xyz;
  logic [1:0] new_mode;

  assign win_req   = (win_id_q == REQ_B) ? req_b_i : req_a_i;
  assign win_xyz   = (win_id_q == REQ_B) ? xyz_b_i : xyz_a_i;
  assign new_mode  = (arb_gnt_idx == REQ_B) ? mode_b_i : mode_a_i;
  assign burst_inc = burst_q + 1'b1;

  // A RUN cycle only counts while the owner still requests; the cycle it drops is the exit.
  assign run_act = (state_q == ST_RUN) && win_req;

  // Outside IDLE the arbiter sees only the owner, so its index names the burst being retired.
  assign arb_req = (state_q == ST_IDLE) ? {req_b_i, req_a_i}
                                        : ((win_id_q == REQ_B) ? 2'b10 : 2'b01);

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (arb_req),
    .update_i  (arb_update),
    .gnt_idx_o (arb_gnt_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    win_id_d   = win_id_q;
    cur_mode_d = cur_mode_q;
    dp_s_d     = dp_s_q;
    rst_cnt_d  = rst_cnt_q;
    burst_d    = burst_q;
    dp_xyz_d   = 3'b000;
    dp_reset_d = 1'b0;
    arb_update = 1'b0;
    tag1_d     = '{valid: run_act, id: win_id_q};
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (arb_any) begin
          win_id_d = arb_gnt_idx;
          if (new_mode == cur_mode_q) begin
            state_d = ST_RUN;
          end else begin
            state_d    = ST_SWITCH;
            dp_reset_d = 1'b1;
            dp_s_d     = new_mode;
            cur_mode_d = new_mode;
            rst_cnt_d  = '0;
          end
        end
      end
      ST_SWITCH: begin
        dp_reset_d = 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          dp_reset_d = 1'b0;
          state_d    = win_req ? ST_RUN : ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (win_req) begin
          dp_xyz_d = win_xyz;
          burst_d  = burst_inc;
          if (burst_inc == BURST_MAX) begin
            state_d    = ST_IDLE;
            arb_update = 1'b1;
          end
        end else begin
          state_d    = ST_IDLE;
          arb_update = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      win_id_q   <= REQ_A;
      cur_mode_q <= MODE_00;
      dp_s_q     <= MODE_00;
      rst_cnt_q  <= '0;
      burst_q    <= '0;
      dp_xyz_q   <= 3'b000;
      dp_reset_q <= 1'b1;
      tag1_q     <= '0;
      tag2_q     <= '0;
    end else begin
      state_q    <= state_d;
      win_id_q   <= win_id_d;
      cur_mode_q <= cur_mode_d;
      dp_s_q     <= dp_s_d;
      rst_cnt_q  <= rst_cnt_d;
      burst_q    <= burst_d;
      dp_xyz_q   <= dp_xyz_d;
      dp_reset_q <= dp_reset_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag1_q;
    end
  end

  assign gnt_a_o     = run_act && (win_id_q == REQ_A);
  assign gnt_b_o     = run_act && (win_id_q == REQ_B);
  assign t_valid_a_o = tag2_q.valid && (tag2_q.id == REQ_A);
  assign t_valid_b_o = tag2_q.valid && (tag2_q.id == REQ_B);
  assign t_a_o       = t_valid_a_o && dp_t_i;
  assign t_b_o       = t_valid_b_o && dp_t_i;

  assign {dp_x_o, dp_y_o, dp_z_o} = dp_xyz_q;
  assign {dp_s1_o, dp_s0_o}       = dp_s_q;
  assign dp_reset_o               = dp_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_ff_mode_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ff_mode_sequencer : directed bench with a behavioural flip-flop datapath |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_ff_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] mode_a = 2'b00, mode_b = 2'b00;
  logic [2:0] xyz_a = 3'b000, xyz_b = 3'b000;
  logic       gnt_a, t_a, t_valid_a, gnt_b, t_b, t_valid_b;
  logic       dp_x, dp_y, dp_z, dp_s0, dp_s1, dp_reset;
  logic       dp_t = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_mode_sequencer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_a_i     (req_a),
    .mode_a_i    (mode_a),
    .xyz_a_i     (xyz_a),
    .gnt_a_o     (gnt_a),
    .t_a_o       (t_a),
    .t_valid_a_o (t_valid_a),
    .req_b_i     (req_b),
    .mode_b_i    (mode_b),
    .xyz_b_i     (xyz_b),
    .gnt_b_o     (gnt_b),
    .t_b_o       (t_b),
    .t_valid_b_o (t_valid_b),
    .dp_x_o      (dp_x),
    .dp_y_o      (dp_y),
    .dp_z_o      (dp_z),
    .dp_s0_o     (dp_s0),
    .dp_s1_o     (dp_s1),
    .dp_reset_o  (dp_reset),
    .dp_t_i      (dp_t)
  );

  // Flip-flop datapath: 00 D(X), 01 T(X), 10 JK(X,Y), 11 SR(X,Y).
  always @(posedge clk) begin
    if (dp_reset) dp_t <= 1'b0;
    else begin
      case ({dp_s1, dp_s0})
        2'b00:   dp_t <= dp_x;
        2'b01:   dp_t <= dp_t ^ dp_x;
        2'b10:   dp_t <= (dp_x & ~dp_t) | (~dp_y & dp_t);
        default: dp_t <= dp_x | (dp_t & ~dp_y);
      endcase
    end
  end

  // {gnt_a, gnt_b, t_valid_a, t_a, t_valid_b, t_b, dp_reset, dp_s1:s0, dp_x/y/z}
  function automatic logic [11:0] obs();
    return {gnt_a, gnt_b, t_valid_a, t_a, t_valid_b, t_b, dp_reset,
            dp_s1, dp_s0, dp_x, dp_y, dp_z};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step(input logic ra, input logic [1:0] ma, input logic [2:0] xa,
                      input logic rb, input logic [1:0] mb, input logic [2:0] xb,
                      input logic rst);
    @(posedge clk);
    #1;
    req_a = ra; mode_a = ma; xyz_a = xa;
    req_b = rb; mode_b = mb; xyz_b = xb;
    reset = rst;
    @(negedge clk);
  endtask

  function automatic logic ea(int c);
    return (c >= 3 && c <= 10) || (c >= 21 && c <= 28);
  endfunction

  function automatic logic eb(int c);
    return (c >= 12 && c <= 19);
  endfunction

  // vin = {req_a, mode_a, xyz_a, req_b, mode_b, xyz_b}
  typedef struct {
    logic [11:0] vin;
    logic [11:0] vexp;
  } vec_t;

  vec_t vt [15];

  initial begin
    // burst of 4 for A in D mode, then B switching to JK mode for 3 cycles
    vt[0]  = '{12'b1_00_000_0_00_000, 12'b000000_0_00_000};
    vt[1]  = '{12'b1_00_100_0_00_000, 12'b100000_0_00_000};
    vt[2]  = '{12'b1_00_001_0_00_000, 12'b100000_0_00_100};
    vt[3]  = '{12'b1_00_110_0_00_000, 12'b101100_0_00_001};
    vt[4]  = '{12'b1_00_010_0_00_000, 12'b101000_0_00_110};
    vt[5]  = '{12'b0_00_000_0_00_000, 12'b001100_0_00_010};
    vt[6]  = '{12'b0_00_000_1_10_000, 12'b001000_0_00_000};
    vt[7]  = '{12'b0_00_000_1_10_000, 12'b000000_1_10_000};
    vt[8]  = '{12'b0_00_000_1_10_000, 12'b000000_1_10_000};
    vt[9]  = '{12'b0_00_000_1_10_100, 12'b010000_0_10_000};
    vt[10] = '{12'b0_00_000_1_10_010, 12'b010000_0_10_100};
    vt[11] = '{12'b0_00_000_1_10_110, 12'b010011_0_10_010};
    vt[12] = '{12'b0_00_000_0_10_000, 12'b000010_0_10_110};
    vt[13] = '{12'b0_00_000_0_10_000, 12'b000011_0_10_000};
    vt[14] = '{12'b0_00_000_0_10_000, 12'b000000_0_10_000};

    // reset held for three edges
    @(posedge clk);
    @(negedge clk);
    chk("reset_hold", obs(), 12'b000000_1_00_000);
    step(1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'b000, 1'b1);
    step(1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("reset_release", obs(), 12'b000000_1_00_000);

    for (int i = 0; i < 15; i++) begin
      step(vt[i].vin[11], vt[i].vin[10:9], vt[i].vin[8:6],
           vt[i].vin[5], vt[i].vin[4:3], vt[i].vin[2:0], 1'b0);
      chk($sformatf("table_row%0d", i), obs(), vt[i].vexp);
    end

    // both requesting in mode 00 from mode 10: switch, then A,B,A bursts of 8
    for (int c = 0; c < 33; c++) begin
      logic r;
      logic [1:0] ds;
      logic [2:0] dx;
      r  = (c < 29);
      step(r, 2'b00, 3'b101, r, 2'b00, 3'b011, 1'b0);
      ds = (c == 0) ? 2'b10 : 2'b00;
      dx = ea(c - 1) ? 3'b101 : (eb(c - 1) ? 3'b011 : 3'b000);
      chk($sformatf("rr_cycle%0d", c), obs(),
          {ea(c), eb(c), ea(c - 2), ea(c - 2), eb(c - 2), 1'b0,
           (c == 1 || c == 2), ds, dx});
    end

    // B in SR mode, reset lands in its third RUN cycle
    step(1'b0, 2'b00, 3'b000, 1'b1, 2'b11, 3'b100, 1'b0);
    chk("abort_idle", obs(), 12'b000000_0_00_000);
    step(1'b0, 2'b00, 3'b000, 1'b1, 2'b11, 3'b100, 1'b0);
    chk("abort_sw0", obs(), 12'b000000_1_11_000);
    step(1'b0, 2'b00, 3'b000, 1'b1, 2'b11, 3'b100, 1'b0);
    chk("abort_sw1", obs(), 12'b000000_1_11_000);
    step(1'b0, 2'b00, 3'b000, 1'b1, 2'b11, 3'b100, 1'b0);
    chk("abort_run0", obs(), 12'b010000_0_11_000);
    step(1'b0, 2'b00, 3'b000, 1'b1, 2'b11, 3'b100, 1'b0);
    chk("abort_run1", obs(), 12'b010000_0_11_100);
    step(1'b0, 2'b00, 3'b000, 1'b1, 2'b11, 3'b100, 1'b1);
    chk("abort_run2", obs(), 12'b010011_0_11_100);
    step(1'b0, 2'b00, 3'b000, 1'b0, 2'b11, 3'b000, 1'b0);
    chk("abort_after", obs(), 12'b000000_1_00_000);
    step(1'b0, 2'b00, 3'b000, 1'b0, 2'b11, 3'b000, 1'b0);
    chk("abort_tail", obs(), 12'b000000_0_00_000);
    step(1'b1, 2'b00, 3'b101, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("mode00_idle", obs(), 12'b000000_0_00_000);
    step(1'b1, 2'b00, 3'b101, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("mode00_noswitch", obs(), 12'b100000_0_00_000);
    step(1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("mode00_exit", obs(), 12'b000000_0_00_101);
    step(1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("mode00_resp", obs(), 12'b001100_0_00_000);

    // A abandons its request during the switch pulse to mode 01
    step(1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("drop_idle", obs(), 12'b000000_0_00_000);
    step(1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("drop_sw0", obs(), 12'b000000_1_01_000);
    step(1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("drop_sw1", obs(), 12'b000000_1_01_000);
    step(1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("drop_idle1", obs(), 12'b000000_0_01_000);
    step(1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("drop_idle2", obs(), 12'b000000_0_01_000);
    step(1'b1, 2'b01, 3'b110, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("keep_idle", obs(), 12'b000000_0_01_000);
    step(1'b1, 2'b01, 3'b110, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("keep_run", obs(), 12'b100000_0_01_000);
    step(1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("keep_exit", obs(), 12'b000000_0_01_110);
    step(1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
    chk("keep_resp", obs(), 12'b001100_0_01_000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
